// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_pkg
//  Description : Shared definitions for the two-port SRAM arbiter.
//                - Default SRAM address and data widths.
//                - Arbiter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    localparam int AW_DEFAULT = 16;
    localparam int DW_DEFAULT = 32;

    // IDLE : both ports compete, round-robin on conflict
    // OWN0 : port 0 holds the SRAM (locked read-modify-write in progress)
    // OWN1 : port 1 holds the SRAM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage : sram_arbiter_pkg
`default_nettype wire

// File: rtl/sram_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sram_rr_pick
//  Description : Two-way round-robin selector. Pure combinational.
//  Ports       : req0_i, req1_i - request pair
//                ptr_i          - priority pointer (0: port 0 wins a tie)
//                gnt_o[1:0]     - one-hot grant (bit N = port N), 0 if idle
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_rr_pick (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end else if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule : sram_rr_pick
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Arbitrates two requesters onto one synchronous single-port
//                SRAM. One access per cycle, round-robin on conflict, and a
//                lock input that lets a port keep ownership across a
//                read-modify-write sequence.
//  Ports       : clk, reset_n (async assert, active-low)
//                reqN/weN/lockN/addrN/wdataN - requester N command
//                gntN    - combinational grant, access issued this cycle
//                rvalidN - registered, one cycle after a read grant to N
//                rdata   - sram_DO passed straight through
//                sram_*  - SRAM port (SRAM instantiated outside)
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sram_ADDR,
    output logic [DW-1:0] sram_DI,
    output logic          sram_EN,
    output logic          sram_WE,
    input  logic [DW-1:0] sram_DO
);

    arb_state_t    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] di_q;
    logic [1:0]    w_pick;

    sram_rr_pick u_pick (
        .req0_i (req0),
        .req1_i (req1),
        .ptr_i  (ptr_q),
        .gnt_o  (w_pick)
    );

    // ------------------------------------------------------------------
    // Grant, next state, pointer and rvalid pipeline
    // ------------------------------------------------------------------
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_d   = state_q;
        ptr_d     = ptr_q;

        case (state_q)
            ST_IDLE: begin
                gnt0 = w_pick[0];
                gnt1 = w_pick[1];
            end
            ST_OWN0: gnt0 = req0;
            ST_OWN1: gnt1 = req1;
            default: ;
        endcase

        // Grants are gated by the raw reset so nothing reaches the SRAM
        // while reset is held, independent of the clock.
        gnt0 = gnt0 & reset_n;
        gnt1 = gnt1 & reset_n;

        if (gnt0) begin
            state_d = lock0 ? ST_OWN0 : ST_IDLE;
            ptr_d   = 1'b1;
        end else if (gnt1) begin
            state_d = lock1 ? ST_OWN1 : ST_IDLE;
            ptr_d   = 1'b0;
        end else if (state_q == ST_OWN0 && !lock0 && !req0) begin
            // Owner walked away without a final access: release ownership.
            state_d = ST_IDLE;
        end else if (state_q == ST_OWN1 && !lock1 && !req1) begin
            state_d = ST_IDLE;
        end

        rvalid0_d = gnt0 & ~we0;
        rvalid1_d = gnt1 & ~we1;
    end

    // ------------------------------------------------------------------
    // SRAM port mux; address/data hold their last driven value when idle
    // ------------------------------------------------------------------
    always_comb begin
        sram_ADDR = addr_q;
        sram_DI   = di_q;
        sram_WE   = 1'b0;
        if (gnt0) begin
            sram_ADDR = addr0;
            sram_DI   = wdata0;
            sram_WE   = we0;
        end else if (gnt1) begin
            sram_ADDR = addr1;
            sram_DI   = wdata1;
            sram_WE   = we1;
        end
    end

    assign sram_EN = gnt0 | gnt1;
    assign rdata   = sram_DO;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            addr_q    <= '0;
            di_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            addr_q    <= sram_ADDR;
            di_q      <= sram_DI;
        end
    end

endmodule : sram_arbiter
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, default 16, SRAM address width.
REQ-002 Parameter DW, default 32, SRAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0, req1  input  1 each  access request from port 0 / port 1, held until granted.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-007 lock0, lock1  input  1 each  keep ownership after this grant (read-modify-write sequences).
REQ-008 addr0, addr1  input  AW each  word address.
REQ-009 wdata0, wdata1  input  DW each  write data.
REQ-010 gnt0, gnt1  output  1 each  combinational; high in the cycle the port's access is issued to SRAM.
REQ-011 rvalid0, rvalid1  output  1 each  registered; high one cycle, exactly one cycle after a read grant.
REQ-012 rdata  output  DW  equals sram_DO, passed through unregistered; valid when either rvalidN is high.
REQ-013 sram_ADDR, sram_DI, sram_EN, sram_WE  output  AW/DW/1/1  SRAM port, combinational from the granted requester.
REQ-014 sram_DO  input  DW  SRAM read data, valid after the rising edge following an EN=1, WE=0 cycle.

Function
REQ-015 Per cycle, at most one of gnt0/gnt1 is high; sram_EN equals gnt0|gnt1.
REQ-016 No grant while neither reqN is high: sram_EN=0; sram_ADDR and sram_DI hold their last values.
REQ-017 FSM states IDLE, OWN0, OWN1; reset state is IDLE.
REQ-018 IDLE, one request: grant that port.
REQ-019 IDLE, both requests: grant the port indicated by the 1-bit priority pointer.
REQ-020 After any grant to port N, the pointer points to the other port.
REQ-021 Grant to port N with lockN=1: next state OWNN.
REQ-022 Grant to port N with lockN=0: stay in IDLE.
REQ-023 OWNN: only port N is eligible; the other port's request is held ungranted regardless of the pointer.
REQ-024 OWNN, grant with lockN=0: return to IDLE.
REQ-025 OWNN, lockN=0 and reqN=0: return to IDLE with no grant in that cycle.
REQ-026 Read grant to port N: rvalidN=1 on the following cycle; rdata carries sram_DO for that address.
REQ-027 Write grant: no rvalid is generated.
REQ-028 Back-to-back grants are allowed; throughput is one access per cycle.
REQ-029 A read grant in cycle k and any grant in cycle k+1 are both legal; rvalid for the read occurs in k+1.
REQ-030 Address wrap: no arithmetic on addresses; all AW bits are passed through unmodified, including the value 2^AW-1.

Reset
REQ-031 reset_n low, asynchronously: state=IDLE, pointer=0, rvalid0=rvalid1=0.
REQ-032 Gnt0/gnt1 and sram_EN are 0 while reset_n is low, whatever the request inputs.
REQ-033 Registered sram_ADDR/sram_DI hold values are 0 on reset.
REQ-034 Reset during a locked sequence drops ownership; a pending rvalid is cancelled.
REQ-035 First cycle after reset deassertion behaves as IDLE with pointer=0.

Structure
REQ-036 Shared package holds the FSM state encoding (IDLE=0, OWN0=1, OWN1=2) and the AW/DW defaults.
REQ-037 One sub-module, sram_rr_pick: 2-way round-robin select (req pair + pointer -> one-hot grant); FSM, rvalid pipeline and muxing stay in sram_arbiter.
REQ-038 The SRAM itself is instantiated outside this block.

Verification
REQ-039 Port 0 writes addr 0x0005 = 0x0000_0005, then reads 0x0005 -> gnt0 each cycle; rvalid0 one cycle after the read; rdata=0x0000_0005.
REQ-040 Both ports request from reset -> grants alternate gnt0, gnt1, gnt0, gnt1.
REQ-041 Port 1 reads 0x1234 with lock1=1, then writes 0x1234 = rdata+1 with lock1=0, while req0 is held -> gnt0 stays low until after the write; memory then holds the incremented value.
REQ-042 Port 0 writes 0xFFFF = 0xDEAD_BEEF, then port 1 reads 0xFFFF -> rvalid1 with rdata=0xDEAD_BEEF; rvalid0 stays low.
REQ-043 reset_n pulsed low mid-sequence in OWN0 with a read just granted -> rvalid0 not asserted; after release, req1 alone is granted the next cycle.
REQ-044 Full 65536-address sweep, alternating ports, each writing mem[i]=i then reading it back -> every read returns i[15:0] in the low bits.
